// File: rtl/arm_defs.sv
// arm_defs: shared widths and rotate helper for operand-2 immediate encoding
package arm_defs;
  localparam int ROT_W = 4;
  localparam int IMM8_W = 8;
  localparam int SHIFT_OP_W = 12;
  localparam int ROT_STEPS = 16;
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    return (v << sh) | (v >> (6'd32 - {1'b0, sh}));
  endfunction
endpackage

// File: rtl/rot_fit_checker.sv
// rot_fit_checker: tests whether value is imm8 rotated right by 2*rot
module rot_fit_checker
  import arm_defs::*;
(
  input  logic [31:0]       value,
  input  logic [ROT_W-1:0]  rot,
  output logic              fits,
  output logic [IMM8_W-1:0] imm8
);
  logic [31:0] rolled;
  assign rolled = rol32(value, {rot, 1'b0});
  assign fits = rolled[31:IMM8_W] == '0;
  assign imm8 = rolled[IMM8_W-1:0];
endmodule

// File: rtl/imm_rotate_encoder.sv
// imm_rotate_encoder: iterative search for a {rot, imm8} encoding of a 32-bit constant
module imm_rotate_encoder
  import arm_defs::*;
#(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SHIFT_OP_W-1:0] shift_operand,
  output logic                  found
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [4:0] rot_cnt_q, rot_cnt_d;
  logic [31:0] value_q, value_d;
  logic [SHIFT_OP_W-1:0] so_q, so_d;
  logic found_q, found_d;
  logic [CHECKS_PER_CYCLE-1:0] fits;
  logic [IMM8_W-1:0] imm [CHECKS_PER_CYCLE];
  logic hit;
  logic [ROT_W-1:0] pick_r;
  logic [IMM8_W-1:0] pick_imm;
  for (genvar i = 0; i < CHECKS_PER_CYCLE; i++) begin : g_chk
    rot_fit_checker u_chk (
      .value(value_q),
      .rot  (rot_cnt_q[ROT_W-1:0] + ROT_W'(i)),
      .fits (fits[i]),
      .imm8 (imm[i])
    );
  end
  // Lowest candidate index wins, giving the smallest legal rotation
  always_comb begin
    hit = 1'b0;
    pick_r = '0;
    pick_imm = '0;
    for (int i = 0; i < CHECKS_PER_CYCLE; i++) begin
      if (fits[i] && !hit) begin
        hit = 1'b1;
        pick_r = rot_cnt_q[ROT_W-1:0] + ROT_W'(i);
        pick_imm = imm[i];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rot_cnt_d = rot_cnt_q;
    value_d = value_q;
    so_d = so_q;
    found_d = found_q;
    case (state_q)
      IDLE: if (in_valid) begin
        value_d = value;
        rot_cnt_d = '0;
        state_d = SEARCH;
      end
      SEARCH: if (hit) begin
        so_d = {pick_r, pick_imm};
        found_d = 1'b1;
        state_d = DONE;
      end else if (rot_cnt_q + 5'(CHECKS_PER_CYCLE) == 5'(ROT_STEPS)) begin
        so_d = '0;
        found_d = 1'b0;
        state_d = DONE;
      end else begin
        rot_cnt_d = rot_cnt_q + 5'(CHECKS_PER_CYCLE);
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rot_cnt_q <= '0;
      value_q <= '0;
      so_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rot_cnt_q <= rot_cnt_d;
      value_q <= value_d;
      so_q <= so_d;
      found_q <= found_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign shift_operand = so_q;
  assign found = found_q;
endmodule

// File: tb/tb_imm_rotate_encoder.sv
// tb_imm_rotate_encoder: directed table plus corner sequences across C = 1, 4, 16
module tb_imm_rotate_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] iv = '0, ordy = '0, ird, ov, fnd;
  logic [31:0] val [3];
  logic [11:0] so [3];
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;

  imm_rotate_encoder #(.CHECKS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ird[0]),
    .value(val[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .shift_operand(so[0]), .found(fnd[0]));
  imm_rotate_encoder #(.CHECKS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ird[1]),
    .value(val[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .shift_operand(so[1]), .found(fnd[1]));
  imm_rotate_encoder #(.CHECKS_PER_CYCLE(16)) u_c16 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ird[2]),
    .value(val[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .shift_operand(so[2]), .found(fnd[2]));

  typedef struct {
    logic [31:0] v;
    logic [11:0] so;
    logic        f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int sh);
    logic [63:0] d;
    d = {v, v} >> sh;
    return d[31:0];
  endfunction

  // Reference encoder: scan rotations upward and decode-check each candidate
  function automatic logic [12:0] ref_enc(input logic [31:0] v);
    for (int r = 0; r < 16; r++) begin
      for (int b = 0; b < 256; b++) begin
        if (ror32(32'(b), 2 * r) == v) return {1'b1, 4'(r), 8'(b)};
      end
    end
    return 13'h0;
  endfunction

  function automatic int cpc(input int k);
    return k == 0 ? 1 : k == 1 ? 4 : 16;
  endfunction

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff(input int k);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
  endtask

  task automatic run(input int k, input logic [31:0] v, input logic [11:0] eso, input logic ef, input logic chk_lat);
    int lat, elat;
    elat = ef ? int'(eso[11:8]) / cpc(k) + 1 : 16 / cpc(k);
    @(negedge clk);
    val[k] = v;
    iv[k] = 1'b1;
    chk($sformatf("in_ready_c%0d_%h", cpc(k), v), 32'(ird[k]), 32'd1);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    wait_out(k, lat);
    if (chk_lat) chk($sformatf("latency_c%0d_%h", cpc(k), v), 32'(lat), 32'(elat));
    chk($sformatf("found_c%0d_%h", cpc(k), v), 32'(fnd[k]), 32'(ef));
    chk($sformatf("shift_op_c%0d_%h", cpc(k), v), 32'(so[k]), 32'(eso));
    handoff(k);
    chk($sformatf("idle_after_c%0d_%h", cpc(k), v), {30'd0, ov[k], ird[k]}, 32'd1);
  endtask

  initial begin
    vec_t tbl [11];
    logic [11:0] hold_so;
    logic [12:0] m;
    logic [31:0] rv;
    int lat;
    logic bad;
    tbl = '{
      '{32'h0000_00FF, 12'h0FF, 1'b1},
      '{32'hFF00_0000, 12'h4FF, 1'b1},
      '{32'h0000_0104, 12'hF41, 1'b1},
      '{32'hF000_000F, 12'h2FF, 1'b1},
      '{32'h0000_0101, 12'h000, 1'b0},
      '{32'h0000_0000, 12'h000, 1'b1},
      '{32'h3FC0_0000, 12'h5FF, 1'b1},
      '{32'h0000_0001, 12'h001, 1'b1},
      '{32'h8000_0000, 12'h102, 1'b1},
      '{32'h0000_03FC, 12'hFFF, 1'b1},
      '{32'hFFFF_FFFF, 12'h000, 1'b0}
    };
    for (int k = 0; k < 3; k++) val[k] = '0;
    rst = 1'b1;
    #12;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state_c%0d", cpc(k)), {18'd0, ird[k], ov[k], so[k]}, 32'h2000);
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 11; i++) run(k, tbl[i].v, tbl[i].so, tbl[i].f, 1'b1);

    // Back-pressure: DONE must hold and refuse a new value until handoff
    @(negedge clk);
    val[0] = 32'h0000_00FF;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    val[0] = 32'hFF00_0000;
    wait_out(0, lat);
    hold_so = so[0];
    chk("bp_first_result", 32'(hold_so), 32'h0FF);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (so[0] !== hold_so || !ov[0] || ird[0] || !fnd[0]) bad = 1'b1;
    end
    chk("bp_hold_stable", 32'(bad), 32'd0);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp_idle_after_handoff", {30'd0, ov[0], ird[0]}, 32'd1);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("bp_second_accept", 32'(ird[0]), 32'd0);
    wait_out(0, lat);
    chk("bp_second_latency", 32'(lat), 32'd5);
    chk("bp_second_result", 32'(so[0]), 32'h4FF);
    handoff(0);

    // Async reset in the middle of an unencodable search
    @(negedge clk);
    val[0] = 32'h0000_0101;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {18'd0, ird[0], ov[0], so[0]}, 32'h2000);
    chk("rst_async_found", 32'(fnd[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ov[0] || !ird[0]) bad = 1'b1;
    end
    chk("rst_no_result", 32'(bad), 32'd0);

    // Random sweep: round-trip and lowest-rotation rule against the reference
    for (int i = 0; i < 24; i++) begin
      rv = (i % 3 == 2) ? $urandom : ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
      m = ref_enc(rv);
      for (int k = 0; k < 3; k++) begin
        run(k, rv, m[11:0], m[12], 1'b0);
        if (m[12]) chk($sformatf("roundtrip_c%0d_%h", cpc(k), rv), ror32({24'd0, so[k][7:0]}, 2 * int'(so[k][11:8])), rv);
      end
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
